// File: rtl/sa_wb_arbiter_pkg.sv
// rtl/sa_wb_arbiter_pkg.sv - shared defaults and entry type for the write-back arbiter
package sa_wb_arbiter_pkg;
  localparam int DEF_SA_NUM          = 4;
  localparam int DEF_SA_OUTPUT_WIDTH = 16;
  localparam int DEF_SRAM_ADDR_SIZE  = 10;
  localparam int DEF_FIFO_DEPTH      = 4;

  typedef struct packed {
    logic [DEF_SRAM_ADDR_SIZE-1:0]  addr;
    logic [DEF_SA_OUTPUT_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/sa_wb_arbiter_if.sv
// rtl/sa_wb_arbiter_if.sv - per-SA write streams in, shared SRAM write port and status out
interface sa_wb_arbiter_if #(
  parameter int SA_NUM          = sa_wb_arbiter_pkg::DEF_SA_NUM,
  parameter int SA_OUTPUT_WIDTH = sa_wb_arbiter_pkg::DEF_SA_OUTPUT_WIDTH,
  parameter int SRAM_ADDR_SIZE  = sa_wb_arbiter_pkg::DEF_SRAM_ADDR_SIZE,
  parameter int FIFO_DEPTH      = sa_wb_arbiter_pkg::DEF_FIFO_DEPTH
);
  localparam int SW = (SA_NUM > 1) ? $clog2(SA_NUM) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                                             clear;
  logic [SA_NUM-1:0]                                wr_valid;
  logic [SA_NUM-1:0][SRAM_ADDR_SIZE-1:0]            wr_addr;
  logic [SA_NUM-1:0][SA_OUTPUT_WIDTH-1:0]           wr_data;
  logic                                             sram_ready;
  logic                                             sram_wen;
  logic [SRAM_ADDR_SIZE-1:0]                        sram_addr;
  logic [SA_OUTPUT_WIDTH-1:0]                       sram_wdata;
  logic [SW-1:0]                                    sram_src;
  logic [SA_NUM-1:0][CW-1:0]                        fifo_count;
  logic [SA_NUM-1:0]                                overflow;
  logic                                             idle;

  modport master (
    output clear, wr_valid, wr_addr, wr_data, sram_ready,
    input  sram_wen, sram_addr, sram_wdata, sram_src, fifo_count, overflow, idle
  );

  modport slave (
    input  clear, wr_valid, wr_addr, wr_data, sram_ready,
    output sram_wen, sram_addr, sram_wdata, sram_src, fifo_count, overflow, idle
  );
endinterface

// File: rtl/sa_wb_fifo.sv
// rtl/sa_wb_fifo.sv - single-clock FIFO; push to full is accepted only alongside a pop
module sa_wb_fifo
  import sa_wb_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_SRAM_ADDR_SIZE + DEF_SA_OUTPUT_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && (!o_full || i_pop);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/sa_wb_arbiter.sv
// rtl/sa_wb_arbiter.sv - buffers per-SA pooled outputs and drains them round-robin onto one SRAM write port
module sa_wb_arbiter
  import sa_wb_arbiter_pkg::*;
#(
  parameter int SA_NUM          = DEF_SA_NUM,
  parameter int SA_OUTPUT_WIDTH = DEF_SA_OUTPUT_WIDTH,
  parameter int SRAM_ADDR_SIZE  = DEF_SRAM_ADDR_SIZE,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic          i_clk,
  input  logic          i_reset,
  sa_wb_arbiter_if.slave io_bus
);
  localparam int SW = (SA_NUM > 1) ? $clog2(SA_NUM) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = SRAM_ADDR_SIZE + SA_OUTPUT_WIDTH;

  logic [SA_NUM-1:0]          w_empty;
  logic [SA_NUM-1:0]          w_full;
  logic [SA_NUM-1:0]          w_pop;
  logic [SA_NUM-1:0]          w_drop;
  logic [EW-1:0]              w_head [SA_NUM];
  logic [SA_NUM-1:0][CW-1:0]  w_count;
  logic                       w_gnt_valid;
  logic [SW-1:0]              w_gnt_idx;
  logic [SW-1:0]              w_scan;

  logic                       r_wen;
  logic [SRAM_ADDR_SIZE-1:0]  r_addr;
  logic [SA_OUTPUT_WIDTH-1:0] r_wdata;
  logic [SW-1:0]              r_src;
  logic [SW-1:0]              r_ptr;
  logic [SA_NUM-1:0]          r_ovf;

  for (genvar g = 0; g < SA_NUM; g++) begin : g_fifo
    sa_wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (io_bus.clear),
      .i_push  (io_bus.wr_valid[g]),
      .i_pop   (w_pop[g]),
      .i_data  ({io_bus.wr_addr[g], io_bus.wr_data[g]}),
      .o_data  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_count (w_count[g])
    );
  end

  // First non-empty FIFO at or after the pointer, wrapping past SA_NUM-1.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_scan      = '0;
    for (int k = 0; k < SA_NUM; k++) begin
      w_scan = SW'((int'(r_ptr) + k) % SA_NUM);
      if (io_bus.sram_ready && !w_gnt_valid && !w_empty[w_scan]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = w_scan;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_gnt_valid) w_pop[w_gnt_idx] = 1'b1;
  end

  assign w_drop = io_bus.wr_valid & w_full & ~w_pop;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
      r_ovf   <= '0;
    end else if (io_bus.clear) begin
      r_wen <= 1'b0;
      r_ptr <= '0;
      r_ovf <= '0;
    end else begin
      r_wen <= w_gnt_valid;
      r_ovf <= r_ovf | w_drop;
      if (w_gnt_valid) begin
        {r_addr, r_wdata} <= w_head[w_gnt_idx];
        r_src             <= w_gnt_idx;
        r_ptr             <= (w_gnt_idx == SW'(SA_NUM - 1)) ? '0 : w_gnt_idx + SW'(1);
      end
    end
  end

  assign io_bus.sram_wen   = r_wen;
  assign io_bus.sram_addr  = r_addr;
  assign io_bus.sram_wdata = r_wdata;
  assign io_bus.sram_src   = r_src;
  assign io_bus.fifo_count = w_count;
  assign io_bus.overflow   = r_ovf;
  assign io_bus.idle       = (&w_empty) && !r_wen;
endmodule

// File: tb/tb_sa_wb_arbiter.sv
// tb/tb_sa_wb_arbiter.sv - directed scoreboard bench for sa_wb_arbiter
module tb_sa_wb_arbiter;
  import sa_wb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sa_wb_arbiter_if #(.SA_NUM(N), .SA_OUTPUT_WIDTH(DW), .SRAM_ADDR_SIZE(AW), .FIFO_DEPTH(D)) wb_bus();

  sa_wb_arbiter #(.SA_NUM(N), .SA_OUTPUT_WIDTH(DW), .SRAM_ADDR_SIZE(AW), .FIFO_DEPTH(D)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .io_bus (wb_bus)
  );

  int        n_assert = 0;
  int        n_fail   = 0;
  wb_entry_t q_exp [N][$];
  int        q_src [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the head of the expected queue of its source SA.
  int        mon_src;
  wb_entry_t mon_e;
  always @(negedge clk) begin
    if (!rst && wb_bus.sram_wen) begin
      mon_src = int'(wb_bus.sram_src);
      if (q_src.size() > 0) chk("wr_src_order", 32'(mon_src), 32'(q_src.pop_front()));
      chk("wr_expected", 32'(q_exp[mon_src].size() > 0), 32'd1);
      if (q_exp[mon_src].size() > 0) begin
        mon_e = q_exp[mon_src].pop_front();
        chk("wr_addr", 32'(wb_bus.sram_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(wb_bus.sram_wdata), 32'(mon_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_it);
    wb_entry_t e;
    wb_bus.wr_valid[i] = 1'b1;
    wb_bus.wr_addr[i]  = a;
    wb_bus.wr_data[i]  = d;
    e.addr = a;
    e.data = d;
    if (expect_it) q_exp[i].push_back(e);
  endtask

  task automatic pulse_clear();
    wb_bus.clear = 1'b1;
    tick();
    wb_bus.clear = 1'b0;
  endtask

  function automatic bit queues_empty();
    bit e = (q_src.size() == 0);
    for (int i = 0; i < N; i++) if (q_exp[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      done = wb_bus.idle && queues_empty();
      if (!done) tick();
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wen"},   32'(wb_bus.sram_wen),   32'd0);
    chk({tag, "_addr"},  32'(wb_bus.sram_addr),  32'd0);
    chk({tag, "_wdata"}, 32'(wb_bus.sram_wdata), 32'd0);
    chk({tag, "_src"},   32'(wb_bus.sram_src),   32'd0);
    chk({tag, "_ovf"},   32'(wb_bus.overflow),   32'd0);
    chk({tag, "_count"}, 32'(wb_bus.fifo_count), 32'd0);
    chk({tag, "_idle"},  32'(wb_bus.idle),       32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wb_bus.clear      = 1'b0;
    wb_bus.wr_valid   = '0;
    wb_bus.wr_addr    = '0;
    wb_bus.wr_data    = '0;
    wb_bus.sram_ready = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Single write from SA2: visible next cycle, written two cycles after the push edge.
    wb_bus.sram_ready = 1'b1;
    push(2, 10'h055, 16'h1234, 1'b1);
    q_src.push_back(2);
    tick();
    wb_bus.wr_valid = '0;
    chk("single_count", 32'(wb_bus.fifo_count[2]), 32'd1);
    chk("single_wen_t1", 32'(wb_bus.sram_wen), 32'd0);
    chk("single_idle_t1", 32'(wb_bus.idle), 32'd0);
    tick();
    chk("single_wen_t2", 32'(wb_bus.sram_wen), 32'd1);
    chk("single_src_t2", 32'(wb_bus.sram_src), 32'd2);
    tick();
    chk("single_wen_t3", 32'(wb_bus.sram_wen), 32'd0);
    chk("single_idle_t3", 32'(wb_bus.idle), 32'd1);

    // Simultaneous requests with the pointer at 0.
    pulse_clear();
    for (int i = 0; i < N; i++) begin
      push(i, AW'(10'h100 + i), DW'(16'h0010 + i), 1'b1);
      q_src.push_back(i);
    end
    tick();
    wb_bus.wr_valid = '0;
    drain("simul_drain");

    // Pointer should now rest at 0: SA0 goes before SA2.
    push(2, 10'h0A2, 16'hC002, 1'b1);
    push(0, 10'h0A0, 16'hC000, 1'b1);
    q_src.push_back(0);
    q_src.push_back(2);
    tick();
    wb_bus.wr_valid = '0;
    drain("ptr_rest_drain");

    // Fairness: SA1 and SA3 push every cycle.
    pulse_clear();
    for (int k = 0; k < 6; k++) begin
      push(1, AW'(10'h200 + k), DW'(16'h1000 + k), 1'b1);
      push(3, AW'(10'h300 + k), DW'(16'h3000 + k), 1'b1);
      q_src.push_back(1);
      q_src.push_back(3);
      tick();
    end
    wb_bus.wr_valid = '0;
    drain("fair_drain");
    chk("fair_ovf", 32'(wb_bus.overflow), 32'd0);

    // Backpressure: three entries held while sram_ready is low.
    wb_bus.sram_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push(0, AW'(10'h010 + k), DW'(16'hA000 + k), 1'b1);
      tick();
    end
    wb_bus.wr_valid = '0;
    chk("bp_count", 32'(wb_bus.fifo_count[0]), 32'd3);
    for (int k = 0; k < 5; k++) begin
      chk("bp_wen_low", 32'(wb_bus.sram_wen), 32'd0);
      tick();
    end
    wb_bus.sram_ready = 1'b1;
    drain("bp_drain");

    // Overflow: the fifth push to a full FIFO is dropped.
    wb_bus.sram_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push(1, AW'(10'h040 + k), DW'(16'hB000 + k), k < 4);
      tick();
    end
    wb_bus.wr_valid = '0;
    chk("ovf_count", 32'(wb_bus.fifo_count[1]), 32'd4);
    chk("ovf_flag", 32'(wb_bus.overflow), 32'b0010);
    wb_bus.sram_ready = 1'b1;
    drain("ovf_drain");
    chk("ovf_sticky", 32'(wb_bus.overflow), 32'b0010);
    pulse_clear();
    chk("ovf_cleared", 32'(wb_bus.overflow), 32'd0);

    // Clear wins over a simultaneous push and grant.
    wb_bus.sram_ready = 1'b0;
    push(0, 10'h3F0, 16'hDEAD, 1'b0);
    push(2, 10'h3F2, 16'hBEEF, 1'b0);
    tick();
    push(2, 10'h3F3, 16'hBEEF, 1'b0);
    wb_bus.wr_valid[0] = 1'b0;
    tick();
    wb_bus.wr_valid = '0;
    chk("clr_pre_count", 32'(wb_bus.fifo_count[2]), 32'd2);
    wb_bus.clear      = 1'b1;
    wb_bus.sram_ready = 1'b1;
    push(0, 10'h3F4, 16'hFACE, 1'b0);
    tick();
    wb_bus.clear    = 1'b0;
    wb_bus.wr_valid = '0;
    chk("clr_count", 32'(wb_bus.fifo_count), 32'd0);
    chk("clr_wen", 32'(wb_bus.sram_wen), 32'd0);
    chk("clr_ovf", 32'(wb_bus.overflow), 32'd0);
    chk("clr_idle", 32'(wb_bus.idle), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("clr_no_write", 32'(wb_bus.sram_wen), 32'd0);
    end

    // Asynchronous reset during a write burst.
    for (int i = 0; i < N; i++) begin
      push(i, AW'(10'h180 + i), DW'(16'h0020 + i), 1'b1);
      q_src.push_back(i);
    end
    tick();
    wb_bus.wr_valid = '0;
    tick();
    chk("burst_wen", 32'(wb_bus.sram_wen), 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    chk("rst_pending", 32'(q_src.size()), 32'd3);
    q_src.delete();
    for (int i = 0; i < N; i++) q_exp[i].delete();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", 32'(wb_bus.idle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sa_wb_arbiter.md
Name: sa_wb_arbiter

Overview:
- Shares the single write-back SRAM write port between the per-SA pooled output streams of the systolic array part.
- Each SA presents an {addr, data, valid} stream that cannot be stalled: valid is the OR of that SA's retimed pool-read enables, plus the retimed write address and pooled value.
- The block buffers each stream in a small per-SA FIFO and drains the FIFOs round-robin onto one registered SRAM write port.
- It flags per-SA overflow and reports idle so the controller knows when write-back is complete.

Parameters:
- SA_NUM, 4, number of systolic arrays (requesters).
- SA_OUTPUT_WIDTH, 16, width of one pooled output word.
- SRAM_ADDR_SIZE, 10, write-back SRAM address width.
- FIFO_DEPTH, 4, entries per SA FIFO; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush: empties FIFOs, resets the round-robin pointer, clears overflow.
- wr_valid  in  SA_NUM  per-SA write request, one entry per asserted cycle.
- wr_addr  in  SA_NUM x SRAM_ADDR_SIZE  per-SA write address.
- wr_data  in  SA_NUM x SA_OUTPUT_WIDTH  per-SA write data.
- sram_ready  in  1  SRAM write port is available this cycle.
- sram_wen  out  1  write strobe, registered.
- sram_addr  out  SRAM_ADDR_SIZE  write address, registered.
- sram_wdata  out  SA_OUTPUT_WIDTH  write data, registered.
- sram_src  out  clog2(SA_NUM)  index of the granted SA, registered; debug and verification use.
- fifo_count  out  SA_NUM x (clog2(FIFO_DEPTH)+1)  per-SA occupancy.
- overflow  out  SA_NUM  sticky per-SA entry-dropped flag.
- idle  out  1  all FIFOs empty and sram_wen low.

Behaviour:
- Reset: all FIFOs empty, round-robin pointer = 0.
- Reset values: sram_wen=0, sram_addr=0, sram_wdata=0, sram_src=0, overflow=0, fifo_count=0, idle=1.
- Reset mid-operation discards all buffered entries immediately.

Push:
- When wr_valid[i]=1, {wr_addr[i], wr_data[i]} is written into FIFO i at the clock edge.
- The entry becomes visible, and counted in fifo_count, the next cycle.

Grant (combinational):
- Requester i is eligible when FIFO i is non-empty.
- If sram_ready=1 and any requester is eligible, grant the first eligible index, searching upward from the pointer with wrap-around from SA_NUM-1 to 0.
- At most one grant per cycle.
- If sram_ready=0, there is no grant.

On grant of i:
- FIFO i pops its head.
- Next cycle: sram_wen=1, sram_addr/sram_wdata = the popped entry, sram_src=i.
- Pointer becomes (i+1) mod SA_NUM.

Without a grant:
- Next cycle sram_wen=0.
- sram_addr, sram_wdata and sram_src hold their last values.
- The pointer holds.

Throughput and latency:
- One write per cycle while sram_ready stays high.
- Minimum latency is 2 cycles: push at edge t, grant during cycle t+1, sram_wen high in cycle t+2.

Full, empty and overflow:
- Push to a full FIFO in a cycle where it is also popped: accepted.
- Push to a full FIFO with no pop: the new entry is dropped, overflow[i] is set and stays set until clear or reset, and the FIFO contents are unchanged.
- Pop of an empty FIFO never occurs, because an empty FIFO is never eligible.

Clear:
- Takes effect at the edge.
- Empties all FIFOs, sets the pointer to 0, sets sram_wen=0, sets overflow=0.
- Clear wins over a simultaneous push or grant: that cycle's wr_valid entries are dropped without setting overflow.

Idle:
- Combinational: idle = (all fifo_count == 0) and !sram_wen.

Address and data:
- Passed through unmodified, no arithmetic.
- FIFO pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.

Decomposition:
- Shared package: the wb_entry_t typedef {addr, data} and the SA_NUM, SA_OUTPUT_WIDTH and SRAM_ADDR_SIZE defaults.
- Sub-module sa_wb_fifo: single-clock FIFO with push/pop/clear and full/empty/count outputs, instantiated SA_NUM times.
- The round-robin grant stays in the top module.

Test Plan:
- Single write: reset, then wr_valid[2]=1 with addr=0x055, data=0x1234 for one cycle, sram_ready=1 → sram_wen=1 exactly 2 cycles later with addr 0x055, data 0x1234, src 2; idle returns to 1 the following cycle.
- Simultaneous requests: all 4 SAs push once in the same cycle with data=0x10+i, pointer at 0 → 4 consecutive writes with src order 0,1,2,3; the pointer then rests at 0.
- Fairness: SA1 and SA3 each push every cycle → writes alternate src 1,3,1,3; neither overflows.
- Backpressure: 3 entries queued in SA0, sram_ready low for 5 cycles → sram_wen=0 throughout; when sram_ready rises, 3 writes follow in push order.
- Overflow: sram_ready=0 and 5 pushes to SA1 (FIFO_DEPTH=4) → fifo_count[1]=4, overflow[1]=1, only the first 4 entries are written once ready; overflow stays 1 until clear.
- Clear/reset mid-operation: FIFOs partially full, assert clear together with wr_valid[0] → next cycle all counts are 0, sram_wen=0, overflow=0, idle=1; then assert async reset during a write burst → outputs return to reset values without waiting for a clock edge.
